octo_frame_scanner: RTL and testbench

// - Downstream of the Octopus game core: sweeps pixel coordinates into the core's VGAx/VGAy

---
 rtl/octo_frame_scanner.sv | 154 +++++++++++++++
 tb/tb_octo_frame_scanner.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/octo_frame_scanner.sv
`default_nettype none
// ============================================================================
// octo_frame_scanner
//   Sweeps raster coordinates into the Octopus core and turns the returning
//   pixel colour into a plot stream for the VGA adapter, one frame at a time.
// Revision: 1.0
// ============================================================================
module octo_frame_scanner #(
  parameter int         H_PIX      = 320,
  parameter int         V_PIX      = 240,
  parameter int         LATENCY    = 2,
  parameter logic [2:0] ON_COLOUR  = 3'b000,
  parameter logic [2:0] OFF_COLOUR = 3'b111
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       VGAcol,
  output logic [8:0] VGAx,
  output logic [7:0] VGAy,
  output logic [8:0] PlotX,
  output logic [7:0] PlotY,
  output logic [2:0] PlotColour,
  output logic       Plot,
  output logic       FrameDone
);

  localparam logic [8:0] X_LAST     = 9'(H_PIX - 1);
  localparam logic [7:0] Y_LAST     = 8'(V_PIX - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e               state_q;
  logic [8:0]           x_q;
  logic [7:0]           y_q;
  logic [2:0]           drain_q;
  logic                 done_q;

  logic [LATENCY-1:0]   dl_v_q;
  logic [8:0]           dl_x_q [LATENCY];
  logic [7:0]           dl_y_q [LATENCY];

  logic [2:0]           colour_q;
  logic [2:0]           colour_d;
  logic                 pix_valid;

  // Dropping Enable aborts the frame from any state; the next run starts at (0,0).
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!Enable) begin
        state_q <= S_IDLE;
        x_q     <= '0;
        y_q     <= '0;
        drain_q <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_SCAN;
            x_q     <= '0;
            y_q     <= '0;
          end
          S_SCAN: begin
            if (x_q == X_LAST && y_q == Y_LAST) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end else if (x_q == X_LAST) begin
              x_q <= '0;
              y_q <= y_q + 8'd1;
            end else begin
              x_q <= x_q + 9'd1;
            end
          end
          S_DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
              state_q <= S_DONE;
              x_q     <= '0;
              y_q     <= '0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q + 3'd1;
            end
          end
          S_DONE: begin
            state_q <= S_SCAN;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Coordinates only advance behind a valid entry, so the last stage keeps
  // the most recently plotted position while bubbles pass through.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      dl_v_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dl_x_q[i] <= '0;
        dl_y_q[i] <= '0;
      end
    end else if (!Enable) begin
      dl_v_q <= '0;
    end else begin
      dl_v_q[0] <= (state_q == S_SCAN);
      if (state_q == S_SCAN) begin
        dl_x_q[0] <= x_q;
        dl_y_q[0] <= y_q;
      end
      for (int i = 1; i < LATENCY; i++) begin
        dl_v_q[i] <= dl_v_q[i-1];
        if (dl_v_q[i-1]) begin
          dl_x_q[i] <= dl_x_q[i-1];
          dl_y_q[i] <= dl_y_q[i-1];
        end
      end
    end
  end

  assign pix_valid = dl_v_q[LATENCY-1];
  assign colour_d  = pix_valid ? (VGAcol ? ON_COLOUR : OFF_COLOUR) : colour_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      colour_q <= '0;
    end else begin
      colour_q <= colour_d;
    end
  end

  assign VGAx       = x_q;
  assign VGAy       = y_q;
  assign PlotX      = dl_x_q[LATENCY-1];
  assign PlotY      = dl_y_q[LATENCY-1];
  assign PlotColour = colour_d;
  assign Plot       = pix_valid;
  assign FrameDone  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_octo_frame_scanner.sv
`default_nettype none
// Bench for octo_frame_scanner on a reduced 12x6 raster so several frames fit in a short run.
module tb_octo_frame_scanner;

  localparam int H = 12;
  localparam int V = 6;
  localparam int L = 2;
  localparam int N = H * V;
  localparam logic [2:0] ON  = 3'b000;
  localparam logic [2:0] OFF = 3'b111;
  localparam logic [8:0] XL  = 9'(H - 1);
  localparam logic [7:0] YL  = 8'(V - 1);

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Enable = 1'b0;
  logic       col_drv = 1'b0;
  logic       chk_mode = 1'b0;
  logic       VGAcol;
  logic [8:0] VGAx, PlotX;
  logic [7:0] VGAy, PlotY;
  logic [2:0] PlotColour;
  logic       Plot, FrameDone;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  octo_frame_scanner #(
    .H_PIX(H), .V_PIX(V), .LATENCY(L), .ON_COLOUR(ON), .OFF_COLOUR(OFF)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .VGAcol(VGAcol),
    .VGAx(VGAx), .VGAy(VGAy), .PlotX(PlotX), .PlotY(PlotY),
    .PlotColour(PlotColour), .Plot(Plot), .FrameDone(FrameDone)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Game-core model: checkerboard colour of the coordinate seen L cycles ago.
  logic hist [L];
  always @(posedge Clock) begin
    hist[0] <= VGAx[0] ^ VGAy[0];
    for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
  end
  assign VGAcol = chk_mode ? hist[L-1] : col_drv;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  pix_t sbq[$];
  int   pcq[$];
  int   fdq[$];
  bit   sb_on = 1'b0;
  bit   wrap_on = 1'b0;
  int   wrap_cnt = 0;
  int   max_x = 0, max_y = 0;
  logic [8:0] prev_vx = '0;
  logic [7:0] prev_vy = '0;

  always @(negedge Clock) begin
    pix_t e;
    if (FrameDone) fdq.push_back(cyc);
    if (wrap_on) begin
      if (int'(VGAx) > max_x) max_x = int'(VGAx);
      if (int'(VGAy) > max_y) max_y = int'(VGAy);
      if (prev_vx == XL && prev_vy == 8'd0) begin
        checks++;
        wrap_cnt++;
        if (!(VGAx == 9'd0 && VGAy == 8'd1)) begin
          errs++;
          $display("FAIL vga_wrap got (%0d,%0d) want (0,1)", VGAx, VGAy);
        end
      end
    end
    prev_vx = VGAx;
    prev_vy = VGAy;
    if (sb_on && Plot) begin
      pcq.push_back(cyc);
      checks++;
      if (sbq.size() == 0) begin
        errs++;
        $display("FAIL plot_extra got (%0d,%0d,%b) want no plot", PlotX, PlotY, PlotColour);
      end else begin
        e = sbq.pop_front();
        if (PlotX !== e.x || PlotY !== e.y || PlotColour !== e.c) begin
          errs++;
          $display("FAIL plot_pixel got (%0d,%0d,%b) want (%0d,%0d,%b)",
                   PlotX, PlotY, PlotColour, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [38:0] act, input logic [38:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push_frame(input bit chkb, input bit colv);
    pix_t p;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        p.x = 9'(x);
        p.y = 8'(y);
        if (chkb) p.c = (((x ^ y) & 1) != 0) ? ON : OFF;
        else      p.c = colv ? ON : OFF;
        sbq.push_back(p);
      end
    end
  endtask

  task automatic do_reset();
    @(posedge Clock); #1;
    Reset = 1'b1;
    Enable = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic wait_xy(input logic [8:0] x, input logic [7:0] y, input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!(VGAx == x && VGAy == y) && n < budget);
    if (!(VGAx == x && VGAy == y)) begin
      checks++;
      errs++;
      $display("FAIL %s timeout got (%0d,%0d) want (%0d,%0d)", nm, VGAx, VGAy, x, y);
    end
  endtask

  task automatic wait_fd(input int budget, input string nm);
    int n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!FrameDone && n < budget);
    if (!FrameDone) begin
      checks++;
      errs++;
      $display("FAIL %s timeout got no FrameDone want pulse", nm);
    end
  endtask

  typedef struct {
    logic       rst, en, col;
    logic [8:0] vx;
    logic [7:0] vy;
    logic       pl;
    logic [8:0] px;
    logic [7:0] py;
    logic [2:0] pc;
    logic       fd;
  } vec_t;

  vec_t vt [16];

  initial begin
    int e;
    vt[0]  = '{1'b1, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 9'd1, 8'd0, 1'b0, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 9'd2, 8'd0, 1'b1, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 9'd3, 8'd0, 1'b1, 9'd1, 8'd0, 3'b111, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 9'd4, 8'd0, 1'b1, 9'd2, 8'd0, 3'b000, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 9'd5, 8'd0, 1'b1, 9'd3, 8'd0, 3'b111, 1'b0};
    vt[8]  = '{1'b0, 1'b0, 1'b1, 9'd0, 8'd0, 1'b0, 9'd3, 8'd0, 3'b111, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd3, 8'd0, 3'b111, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd3, 8'd0, 3'b111, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 9'd1, 8'd0, 1'b0, 9'd3, 8'd0, 3'b111, 1'b0};
    vt[12] = '{1'b0, 1'b1, 1'b1, 9'd2, 8'd0, 1'b1, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[13] = '{1'b1, 1'b1, 1'b0, 9'd3, 8'd0, 1'b1, 9'd1, 8'd0, 3'b111, 1'b0};
    vt[14] = '{1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd0, 8'd0, 3'b000, 1'b0};
    vt[15] = '{1'b0, 1'b1, 1'b1, 9'd0, 8'd0, 1'b0, 9'd0, 8'd0, 3'b000, 1'b0};

    repeat (3) @(posedge Clock);
    for (int i = 0; i < 16; i++) begin
      @(posedge Clock); #1;
      Reset   = vt[i].rst;
      Enable  = vt[i].en;
      col_drv = vt[i].col;
      @(negedge Clock);
      chkv($sformatf("vec%0d", i),
           {VGAx, VGAy, Plot, PlotX, PlotY, PlotColour, FrameDone},
           {vt[i].vx, vt[i].vy, vt[i].pl, vt[i].px, vt[i].py, vt[i].pc, vt[i].fd});
    end

    // Two back-to-back frames with a checkerboard core.
    do_reset();
    chk_mode = 1'b1;
    sbq.delete(); pcq.delete(); fdq.delete();
    push_frame(1'b1, 1'b0);
    push_frame(1'b1, 1'b0);
    sb_on = 1'b1;
    wrap_on = 1'b1;
    Enable = 1'b1;
    e = cyc;
    wait_fd(N + 20, "frame1");
    wait_fd(N + 20, "frame2");
    sb_on = 1'b0;
    wrap_on = 1'b0;
    Enable = 1'b0;
    #1;
    chk("frames_left_in_sb", sbq.size(), 0);
    chk("plot_count_2frames", pcq.size(), 2 * N);
    chk("framedone_count", fdq.size(), 2);
    if (pcq.size() == 2 * N && fdq.size() == 2) begin
      chk("first_plot_cycle", pcq[0], e + 1 + L);
      chk("frame1_done_cycle", fdq[0], e + 1 + N + L);
      chk("frame2_first_plot_gap", pcq[N] - fdq[0], L + 1);
      chk("frame_period", fdq[1] - fdq[0], N + L + 1);
      chk("last_plot_before_done", fdq[0] - pcq[N-1], 1);
    end
    chk("max_vgax", max_x, H - 1);
    chk("max_vgay", max_y, V - 1);
    chk("wrap_count", wrap_cnt, 2);

    // Abort at (5,3), then restart.
    do_reset();
    sbq.delete(); pcq.delete(); fdq.delete();
    push_frame(1'b1, 1'b0);
    sb_on = 1'b1;
    Enable = 1'b1;
    wait_xy(9'd5, 8'd3, N + 10, "abort_point");
    Enable = 1'b0;
    @(negedge Clock);
    chk("abort_plot_off", int'(Plot), 0);
    #1;
    chk("abort_left_in_sb", sbq.size(), N - 40);
    if (sbq.size() > 0) chk("abort_next_pending", int'({sbq[0].x, sbq[0].y}), int'({9'd4, 8'd3}));
    sbq.delete();
    repeat (5) @(negedge Clock);
    chk("abort_no_framedone", fdq.size(), 0);
    @(posedge Clock); #1;
    pcq.delete();
    push_frame(1'b1, 1'b0);
    Enable = 1'b1;
    e = cyc;
    wait_fd(N + 20, "restart_frame");
    sb_on = 1'b0;
    Enable = 1'b0;
    #1;
    chk("restart_sb_empty", sbq.size(), 0);
    if (pcq.size() > 0) chk("restart_first_plot_cycle", pcq[0], e + 1 + L);

    // Reset in the first DRAIN cycle with Enable held high.
    do_reset();
    chk_mode = 1'b0;
    col_drv = 1'b1;
    sbq.delete(); pcq.delete(); fdq.delete();
    push_frame(1'b0, 1'b1);
    sb_on = 1'b1;
    Enable = 1'b1;
    wait_xy(XL, YL, N + 10, "drain_point");
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    chkv("reset_in_drain", {VGAx, VGAy, Plot, PlotX, PlotY, PlotColour, FrameDone}, 39'd0);
    #1;
    chk("drain_dropped", sbq.size(), 1);
    if (sbq.size() > 0) chk("drain_dropped_pixel", int'({sbq[0].x, sbq[0].y}), int'({XL, YL}));
    chk("drain_no_framedone", fdq.size(), 0);
    sbq.delete();
    pcq.delete();
    push_frame(1'b0, 1'b1);
    Reset = 1'b0;
    e = cyc;
    @(negedge Clock);
    @(negedge Clock);
    chk("post_reset_vgax", int'(VGAx), 1);
    wait_fd(N + 20, "post_reset_frame");
    sb_on = 1'b0;
    Enable = 1'b0;
    #1;
    chk("post_reset_sb_empty", sbq.size(), 0);
    if (pcq.size() > 0) chk("post_reset_first_plot", pcq[0], e + 1 + L);

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
`default_nettype wire
